nonce_sweep_scheduler: RTL and testbench

//  Sequences a multi-nonce SHA-256 hash core across consecutive nonce batches.
//  Per batch: launch core, await completion, read NUM_NONCES result words back, compare each to target.

---
 rtl/sha_pkg.sv | 18 +
 rtl/hash_min_tracker.sv | 61 ++++++
 rtl/nonce_sweep_scheduler.sv | 179 +++++++++++++++++
 tb/tb_nonce_sweep_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// Shared types and defaults for the nonce sweep scheduler.
package sha_pkg;

    localparam int unsigned DEFAULT_NUM_NONCES = 16;

    typedef logic [31:0] nonce_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_SCAN,
        S_NEXT,
        S_FINISH
    } sched_state_t;

endpackage

// File: rtl/hash_min_tracker.sv
// Keeps the smallest hash word below target seen since the last clear,
// together with the nonce that produced it. Ties keep the earlier nonce.
module hash_min_tracker
    import sha_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        sample_valid,
    input  logic [31:0] sample_word,
    input  logic [31:0] sample_nonce,
    input  logic [31:0] target,
    output logic        found,
    output logic [31:0] best_hash,
    output logic [31:0] best_nonce
);

    logic   found_q, found_d;
    logic   [31:0] best_hash_q, best_hash_d;
    nonce_t best_nonce_q, best_nonce_d;
    logic   better;

    // Strictly-smaller comparisons so equal words never displace an earlier nonce.
    always_comb begin
        better       = 1'b0;
        found_d      = found_q;
        best_hash_d  = best_hash_q;
        best_nonce_d = best_nonce_q;
        if (clear) begin
            found_d      = 1'b0;
            best_hash_d  = '0;
            best_nonce_d = '0;
        end else if (sample_valid) begin
            better = (sample_word < target) &&
                     (!found_q || (sample_word < best_hash_q));
            if (better) begin
                found_d      = 1'b1;
                best_hash_d  = sample_word;
                best_nonce_d = sample_nonce;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            found_q      <= 1'b0;
            best_hash_q  <= '0;
            best_nonce_q <= '0;
        end else begin
            found_q      <= found_d;
            best_hash_q  <= best_hash_d;
            best_nonce_q <= best_nonce_d;
        end
    end

    assign found      = found_q;
    assign best_hash  = best_hash_q;
    assign best_nonce = best_nonce_q;

endmodule

// File: rtl/nonce_sweep_scheduler.sv
// Runs a multi-nonce hash core over consecutive nonce batches, reads back
// each batch's result words and tracks the best qualifying hash.
module nonce_sweep_scheduler
    import sha_pkg::*;
#(
    parameter int unsigned NUM_NONCES   = DEFAULT_NUM_NONCES,
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned STOP_ON_FIND = 0,
    parameter int unsigned LAUNCH_TMO   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [15:0]       num_batches,
    input  logic [31:0]       nonce_start,
    input  logic [31:0]       target,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              err,
    output logic [31:0]       best_nonce,
    output logic [31:0]       best_hash,
    output logic              core_start,
    output logic [31:0]       core_nonce_base,
    input  logic              core_done,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_read_data
);

    localparam int unsigned CNT_W = $clog2(NUM_NONCES + 1);
    localparam int unsigned TMO_W = (LAUNCH_TMO > 1) ? $clog2(LAUNCH_TMO) : 1;

    sched_state_t      state_q, state_d;
    nonce_t            base_q, base_d;
    logic [15:0]       rem_q, rem_d;
    logic [31:0]       tgt_q, tgt_d;
    logic [ADDR_W-1:0] oaddr_q, oaddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              err_q, err_d;

    logic   trk_clear;
    logic   trk_valid;
    logic   trk_found;
    nonce_t scan_nonce;

    // The core ignores the message address; it is forwarded out of band.
    logic [ADDR_W-1:0] unused_message_addr;
    assign unused_message_addr = message_addr;

    // Word arriving this cycle belongs to the address issued one cycle earlier.
    assign scan_nonce = base_q + nonce_t'(cnt_q) - 32'd1;

    // Next-state and control decode.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rem_d      = rem_q;
        tgt_d      = tgt_q;
        oaddr_d    = oaddr_q;
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        trk_clear  = 1'b0;
        trk_valid  = 1'b0;
        core_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = nonce_start;
                    rem_d     = num_batches;
                    tgt_d     = target;
                    oaddr_d   = output_addr;
                    cnt_d     = '0;
                    tmo_d     = '0;
                    err_d     = 1'b0;
                    trk_clear = 1'b1;
                    state_d   = (num_batches == 16'd0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (core_done) begin
                    core_start = 1'b1;
                    tmo_d      = '0;
                    state_d    = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (!core_done) begin
                    state_d = S_WAIT_DONE;
                end else if (tmo_q == TMO_W'(LAUNCH_TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (core_done) begin
                    cnt_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                trk_valid = (cnt_q != '0);
                if (cnt_q == CNT_W'(NUM_NONCES)) begin
                    state_d = S_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_NEXT: begin
                rem_d = rem_q - 16'd1;
                if ((rem_q == 16'd1) || ((STOP_ON_FIND != 0) && trk_found)) begin
                    state_d = S_FINISH;
                end else begin
                    // Base only advances when another batch is launched, so
                    // core_nonce_base still shows the last batch run at done.
                    base_d  = base_q + nonce_t'(NUM_NONCES);
                    state_d = S_LAUNCH;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            rem_q   <= '0;
            tgt_q   <= '0;
            oaddr_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            tgt_q   <= tgt_d;
            oaddr_q <= oaddr_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    hash_min_tracker u_tracker (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (trk_clear),
        .sample_valid (trk_valid),
        .sample_word  (mem_read_data),
        .sample_nonce (scan_nonce),
        .target       (tgt_q),
        .found        (trk_found),
        .best_hash    (best_hash),
        .best_nonce   (best_nonce)
    );

    assign busy            = (state_q != S_IDLE);
    assign done            = (state_q == S_FINISH);
    assign mem_sel         = (state_q == S_SCAN);
    assign mem_addr        = oaddr_q + ADDR_W'(cnt_q);
    assign core_nonce_base = base_q;
    assign found           = trk_found;
    assign err             = err_q;

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Scoreboard bench: instance 0 has STOP_ON_FIND=0, instance 1 has STOP_ON_FIND=1.
// Each instance gets a behavioural core + result memory model.
module tb_nonce_sweep_scheduler;

    localparam int NN = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        done;
        logic        busy;
        logic        found;
        logic        err;
        logic        core_start;
        logic        mem_sel;
        logic [31:0] best_nonce;
        logic [31:0] best_hash;
        logic [31:0] base;
        logic [15:0] mem_addr;
    } obs_t;

    typedef struct {
        string       nm;
        logic        found;
        logic        err;
        logic [31:0] bn;
        logic [31:0] bh;
        logic [31:0] fb;
        logic [31:0] lb;
        int          starts;
        int          dly;   // 0 none, 1 done one cycle after start, 2 launch timeout
    } exp_t;

    // Stimulus-side inputs per instance
    logic        rstn_v  [2];
    logic        start_v [2];
    logic [15:0] nb_v    [2];
    logic [15:0] oa_v    [2];
    logic [15:0] ma_v    [2];
    logic [31:0] ns_v    [2];
    logic [31:0] tg_v    [2];
    logic        hang    [2];

    // Result memory contents: up to 3 non-default words per instance
    int          nh [2];
    int          hb [2][3];
    int          hi [2][3];
    logic [31:0] hv [2][3];

    // Observation wires
    obs_t        obs      [2];
    int          m_starts [2];
    int          m_scyc   [2];
    int          m_cscyc  [2];
    logic [31:0] m_fb     [2];
    logic [31:0] m_lb     [2];
    logic        m_cdone  [2];

    exp_t q0[$];
    exp_t q1[$];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [31:0] word_for(int g, int b, int idx);
        logic [31:0] w;
        w = 32'hFFFF_FFFF;
        for (int k = 0; k < nh[g]; k++)
            if (hb[g][k] == b && hi[g][k] == idx) w = hv[g][k];
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_i
        logic        done, busy, found, err, cs, msel;
        logic [31:0] bn, bh, base;
        logic [15:0] maddr;
        logic        cdone = 1'b1;
        logic [31:0] rdata = '0;
        int          bcnt = 0;
        int          run = 0;
        int          starts = 0;
        int          scyc = 0;
        int          cscyc = 0;
        logic [31:0] fb = '0;
        logic [31:0] lb = '0;

        nonce_sweep_scheduler #(
            .NUM_NONCES   (NN),
            .ADDR_W       (16),
            .STOP_ON_FIND (g),
            .LAUNCH_TMO   (4)
        ) u_dut (
            .clk             (clk),
            .reset_n         (rstn_v[g]),
            .start           (start_v[g]),
            .message_addr    (ma_v[g]),
            .output_addr     (oa_v[g]),
            .num_batches     (nb_v[g]),
            .nonce_start     (ns_v[g]),
            .target          (tg_v[g]),
            .busy            (busy),
            .done            (done),
            .found           (found),
            .err             (err),
            .best_nonce      (bn),
            .best_hash       (bh),
            .core_start      (cs),
            .core_nonce_base (base),
            .core_done       (cdone),
            .mem_sel         (msel),
            .mem_addr        (maddr),
            .mem_read_data   (rdata)
        );

        // Core model: busy (core_done low) for 3 cycles per launch unless hung.
        always @(posedge clk) begin
            if (start_v[g] && !busy) begin
                starts <= 0;
                run    <= 0;
                fb     <= '0;
                lb     <= '0;
                scyc   <= cyc;
            end
            if (cs) begin
                starts <= starts + 1;
                run    <= run + 1;
                if (starts == 0) fb <= base;
                lb     <= base;
                cscyc  <= cyc;
                if (!hang[g]) begin
                    bcnt  <= 3;
                    cdone <= 1'b0;
                end
            end else if (bcnt > 0) begin
                bcnt <= bcnt - 1;
                if (bcnt == 1) cdone <= 1'b1;
            end
            rdata <= word_for(g, run - 1, int'(maddr - oa_v[g]));
        end

        assign obs[g]      = {done, busy, found, err, cs, msel, bn, bh, base, maddr};
        assign m_starts[g] = starts;
        assign m_scyc[g]   = scyc;
        assign m_cscyc[g]  = cscyc;
        assign m_fb[g]     = fb;
        assign m_lb[g]     = lb;
        assign m_cdone[g]  = cdone;
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
        end
    endtask

    task automatic check_done(int g, exp_t e);
        chk({e.nm, ".busy_at_done"}, 32'(obs[g].busy), 32'd1);
        chk({e.nm, ".found"}, 32'(obs[g].found), 32'(e.found));
        chk({e.nm, ".err"}, 32'(obs[g].err), 32'(e.err));
        chk({e.nm, ".best_nonce"}, obs[g].best_nonce, e.bn);
        chk({e.nm, ".best_hash"}, obs[g].best_hash, e.bh);
        chk({e.nm, ".core_starts"}, 32'(m_starts[g]), 32'(e.starts));
        if (e.starts > 0) begin
            chk({e.nm, ".first_base"}, m_fb[g], e.fb);
            chk({e.nm, ".last_base"}, m_lb[g], e.lb);
        end
        if (e.dly == 1) chk({e.nm, ".done_after_start"}, 32'(cyc - m_scyc[g]), 32'd1);
        if (e.dly == 2) chk({e.nm, ".done_after_core_start"}, 32'(cyc - m_cscyc[g]), 32'd5);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (obs[g].done) begin
                    if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_done inst%0d: got done=1 expected no done", g);
                    end else begin
                        e = (g == 0) ? q0.pop_front() : q1.pop_front();
                        check_done(g, e);
                    end
                end
            end
        end
    endtask

    task automatic set_hits(int g, int n,
                            int b0, int i0, logic [31:0] v0,
                            int b1, int i1, logic [31:0] v1,
                            int b2, int i2, logic [31:0] v2);
        nh[g] = n;
        hb[g][0] = b0; hi[g][0] = i0; hv[g][0] = v0;
        hb[g][1] = b1; hi[g][1] = i1; hv[g][1] = v1;
        hb[g][2] = b2; hi[g][2] = i2; hv[g][2] = v2;
    endtask

    task automatic run(int g, string nm, logic [15:0] nb, logic [15:0] oa,
                       logic [31:0] ns, logic [31:0] tg,
                       logic ef, logic ee, logic [31:0] ebn, logic [31:0] ebh,
                       int est, logic [31:0] efb, logic [31:0] elb, int edly);
        exp_t e;
        e.nm = nm; e.found = ef; e.err = ee; e.bn = ebn; e.bh = ebh;
        e.starts = est; e.fb = efb; e.lb = elb; e.dly = edly;
        if (g == 0) q0.push_back(e); else q1.push_back(e);
        @(negedge clk);
        nb_v[g] = nb; oa_v[g] = oa; ns_v[g] = ns; tg_v[g] = tg;
        ma_v[g] = 16'h1000;
        start_v[g] = 1'b1;
        @(negedge clk);
        start_v[g] = 1'b0;
    endtask

    task automatic wait_sb(int g, string nm);
        int n;
        n = 0;
        while (((g == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got no done within %0d cycles expected done", nm, n);
            if (g == 0) q0.delete(); else q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_zero(int g, string nm);
        chk({nm, ".ctl"}, 32'({obs[g].done, obs[g].busy, obs[g].found, obs[g].err,
                               obs[g].core_start, obs[g].mem_sel}), 32'd0);
        chk({nm, ".best_nonce"}, obs[g].best_nonce, 32'd0);
        chk({nm, ".best_hash"}, obs[g].best_hash, 32'd0);
        chk({nm, ".core_nonce_base"}, obs[g].base, 32'd0);
        chk({nm, ".mem_addr"}, 32'(obs[g].mem_addr), 32'd0);
    endtask

    initial begin
        int n;
        for (int g = 0; g < 2; g++) begin
            rstn_v[g] = 1'b0; start_v[g] = 1'b0; nb_v[g] = '0; oa_v[g] = '0;
            ma_v[g] = '0; ns_v[g] = '0; tg_v[g] = '0; hang[g] = 1'b0; nh[g] = 0;
        end
        fork
            monitor();
        join_none

        repeat (3) @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rstn_v[0] = 1'b1;
        rstn_v[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Single batch, one hit at index 5
        set_hits(0, 1, 0, 5, 32'h0000ABCD, 9, 0, 0, 9, 0, 0);
        run(0, "t1", 16'd1, 16'h2000, 32'h0, 32'h0010_0000,
            1, 0, 32'h5, 32'h0000ABCD, 1, 32'h0, 32'h0, 0);
        wait_sb(0, "t1");

        // Three batches, smaller hit in the last batch, address wrap, ignored start
        set_hits(0, 2, 0, 2, 32'h500, 2, 7, 32'h300, 9, 0, 0);
        run(0, "t2", 16'd3, 16'hFFF8, 32'h100, 32'h0010_0000,
            1, 0, 32'h127, 32'h300, 3, 32'h100, 32'h120, 0);
        repeat (20) @(negedge clk);
        ns_v[0] = 32'hDEAD_0000; nb_v[0] = 16'd1; tg_v[0] = 32'h0;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_sb(0, "t2");

        // Tie keeps the earlier nonce; word equal to target does not qualify
        set_hits(0, 3, 0, 3, 32'h300, 0, 9, 32'h300, 0, 12, 32'h1000);
        run(0, "t2tie", 16'd1, 16'h0010, 32'h40, 32'h1000,
            1, 0, 32'h43, 32'h300, 1, 32'h40, 32'h40, 0);
        wait_sb(0, "t2tie");

        // Equal-to-target at index 0 rejected, last index 15 just below target
        set_hits(0, 2, 0, 0, 32'h1000, 0, 15, 32'h0FFF, 9, 0, 0);
        run(0, "t2edge", 16'd1, 16'h0200, 32'h0, 32'h1000,
            1, 0, 32'hF, 32'h0FFF, 1, 32'h0, 32'h0, 0);
        wait_sb(0, "t2edge");

        // Stop on first batch with a hit
        set_hits(1, 2, 1, 4, 32'h77, 3, 0, 32'h1, 9, 0, 0);
        run(1, "t3", 16'd4, 16'h0400, 32'h0, 32'h0010_0000,
            1, 0, 32'h14, 32'h77, 2, 32'h0, 32'h10, 0);
        wait_sb(1, "t3");

        // Core never goes busy: launch timeout
        hang[0] = 1'b1;
        set_hits(0, 0, 9, 0, 0, 9, 0, 0, 9, 0, 0);
        run(0, "t4", 16'd2, 16'h0000, 32'h300, 32'h0010_0000,
            0, 1, 32'h0, 32'h0, 1, 32'h300, 32'h300, 2);
        wait_sb(0, "t4");
        hang[0] = 1'b0;

        // Zero batches: immediate done, err cleared by the new start
        run(0, "t5zero", 16'd0, 16'h0000, 32'h55, 32'h0010_0000,
            0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0, 1);
        wait_sb(0, "t5zero");

        // Nonce base wraps past 2^32
        set_hits(0, 1, 1, 1, 32'h9, 9, 0, 0, 9, 0, 0);
        run(0, "t5wrap", 16'd2, 16'h0100, 32'hFFFF_FFF0, 32'h0010_0000,
            1, 0, 32'h1, 32'h9, 2, 32'hFFFF_FFF0, 32'h0, 0);
        wait_sb(0, "t5wrap");

        // Reset while the core is running aborts without done
        set_hits(0, 1, 0, 1, 32'h5, 9, 0, 0, 9, 0, 0);
        run(0, "t6abort", 16'd3, 16'h0100, 32'h100, 32'h0010_0000,
            1, 0, 32'h0, 32'h0, 3, 32'h0, 32'h0, 0);
        n = 0;
        while (m_cdone[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6.core_went_busy", 32'(m_cdone[0]), 32'd0);
        q0.delete();
        rstn_v[0] = 1'b0;
        #1;
        chk_zero(0, "t6reset");
        repeat (2) @(negedge clk);
        rstn_v[0] = 1'b1;
        repeat (10) @(negedge clk);

        set_hits(0, 1, 0, 5, 32'h0000ABCD, 9, 0, 0, 9, 0, 0);
        run(0, "t6clean", 16'd1, 16'h2000, 32'h200, 32'h0010_0000,
            1, 0, 32'h205, 32'h0000ABCD, 1, 32'h200, 32'h200, 0);
        wait_sb(0, "t6clean");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
